// File: rtl/fir_pkg.sv
// fir_pkg: width helpers and output narrowing shared by the fir_pipe datapath.
// FIR_SATURATE_EN selects clamping instead of two's-complement wrap in narrow().
package fir_pkg;

    localparam int NW = 128;

    typedef logic signed [NW-1:0] wide_t;

    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

    function automatic int tree_depth(input int taps);
        return clog2(taps);
    endfunction

    function automatic int prod_w(input int dw, input int cw);
        return dw + cw;
    endfunction

    function automatic int acc_w(input int dw, input int cw, input int taps);
        return prod_w(dw, cw) + clog2(taps);
    endfunction

    // Result is sign-correct in its low ow bits; the caller truncates.
    function automatic wide_t narrow(input wide_t v, input int ow);
`ifdef FIR_SATURATE_EN
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (ow - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        wide_t r;
        r = v <<< (NW - ow);
        return r >>> (NW - ow);
`endif
    endfunction

endpackage

// File: rtl/fir_add_tree.sv
// fir_add_tree: registered pairwise reduction of N signed operands in D levels.
// Unused slots hold zero, so an odd operand simply passes through its level.
module fir_add_tree
    import fir_pkg::*;
#(
    parameter int N = 6,
    parameter int W = 35,
    parameter int D = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_data [N],
    output logic                out_valid,
    output logic signed [W-1:0] out_data
);

    logic signed [W-1:0] node  [D][2*N];
    logic signed [W-1:0] sum_d [D][N];
    logic signed [W-1:0] sum_q [D][N];
    logic [D-1:0]        vld_d;
    logic [D-1:0]        vld_q;

    always_comb begin
        for (int j = 0; j < D; j++) begin
            for (int i = 0; i < 2*N; i++) begin
                node[j][i] = '0;
            end
        end
        for (int i = 0; i < N; i++) begin
            node[0][i] = in_data[i];
        end
        for (int j = 1; j < D; j++) begin
            for (int i = 0; i < N; i++) begin
                node[j][i] = sum_q[j-1][i];
            end
        end
        for (int j = 0; j < D; j++) begin
            for (int i = 0; i < N; i++) begin
                sum_d[j][i] = node[j][2*i] + node[j][2*i+1];
            end
        end
        vld_d[0] = in_valid;
        for (int j = 1; j < D; j++) begin
            vld_d[j] = vld_q[j-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int j = 0; j < D; j++) begin
                for (int i = 0; i < N; i++) begin
                    sum_q[j][i] <= '0;
                end
            end
        end else if (en) begin
            vld_q <= vld_d;
            sum_q <= sum_d;
        end
    end

    assign out_valid = vld_q[D-1];
    assign out_data  = sum_q[D-1][0];

endmodule

// File: rtl/fir_pipe.sv
// fir_pipe: stallable direct-form FIR with run-time coefficient load.
// Define FIR_SATURATE_EN to clamp the output instead of wrapping it.
module fir_pipe
    import fir_pkg::*;
#(
    parameter int TAPS  = 6,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int OW    = 16,
    parameter int SHIFT = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic signed [DW-1:0]            in_data,
    input  logic                            coef_we,
    input  logic [fir_pkg::clog2(TAPS)-1:0] coef_addr,
    input  logic signed [CW-1:0]            coef_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [OW-1:0]            out_data
);

    localparam int PW   = prod_w(DW, CW);
    localparam int ACCW = acc_w(DW, CW, TAPS);
    localparam int D    = tree_depth(TAPS);

    logic                   en;
    logic signed [DW-1:0]   x_d [TAPS];
    logic signed [DW-1:0]   x_q [TAPS];
    logic signed [CW-1:0]   c_d [TAPS];
    logic signed [CW-1:0]   c_q [TAPS];
    logic signed [PW-1:0]   p_d [TAPS];
    logic signed [PW-1:0]   p_q [TAPS];
    logic signed [ACCW-1:0] tin [TAPS];
    logic                   v0_d, v0_q;
    logic                   v1_d, v1_q;
    logic                   tree_vld;
    logic signed [ACCW-1:0] tree_sum;
    wide_t                  wide;
    wide_t                  nar;
    logic                   out_valid_d, out_valid_q;
    logic signed [OW-1:0]   out_data_d, out_data_q;

    always_comb begin
        en   = !(out_valid_q && !out_ready);
        x_d  = x_q;
        v0_d = in_valid;
        if (in_valid) begin
            x_d[0] = in_data;
            for (int k = 1; k < TAPS; k++) begin
                x_d[k] = x_q[k-1];
            end
        end
        // Coefficient writes ignore the stall; out-of-range taps match nothing.
        c_d = c_q;
        for (int k = 0; k < TAPS; k++) begin
            if (coef_we && int'(coef_addr) == k) begin
                c_d[k] = coef_data;
            end
        end
        for (int k = 0; k < TAPS; k++) begin
            p_d[k] = PW'(x_q[k]) * PW'(c_q[k]);
            tin[k] = ACCW'(p_q[k]);
        end
        v1_d        = v0_q;
        wide        = wide_t'(tree_sum >>> SHIFT);
        nar         = narrow(wide, OW);
        out_valid_d = tree_vld;
        out_data_d  = tree_vld ? OW'(nar) : out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                c_q[k] <= '0;
                p_q[k] <= '0;
            end
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            c_q <= c_d;
            if (en) begin
                x_q         <= x_d;
                v0_q        <= v0_d;
                p_q         <= p_d;
                v1_q        <= v1_d;
                out_valid_q <= out_valid_d;
                out_data_q  <= out_data_d;
            end
        end
    end

    fir_add_tree #(
        .N (TAPS),
        .W (ACCW),
        .D (D)
    ) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (v1_q),
        .in_data   (tin),
        .out_valid (tree_vld),
        .out_data  (tree_sum)
    );

    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
